// File: rtl/s35932_crc_checker.sv
// Receive-side check-word verifier for the s35932 lanes: recomputes each lane's check bit,
// accumulates per-frame syndromes and error counts, and hands one report per frame downstream.
module s35932_crc_checker #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned BW       = $clog2(FRAME_LEN + 1),
    localparam int unsigned IW       = $clog2(FRAME_LEN)
) (
    input  logic             CK,
    input  logic             RESET_N,
    input  logic             TM0,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic [WIDTH-1:0] in_seed,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [WIDTH-1:0] rpt_syndrome,
    output logic [BW-1:0]    rpt_err_beats,
    output logic [BW-1:0]    rpt_beats,
    output logic [IW-1:0]    rpt_first_err,
    output logic [CNT_W-1:0] err_total,
    output logic             err_sticky,
    input  logic             clr_stats
);

    typedef enum logic [1:0] {StIdle, StAcc, StReport} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] syn_q, syn_d;
    logic [BW-1:0]    errb_q, errb_d;
    logic [BW-1:0]    beats_q, beats_d;
    logic [IW-1:0]    first_q, first_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic             sticky_q, sticky_d;

    logic [WIDTH-1:0] tm_w, par_w, exp_w, syn_w;
    logic             beat_err, accept, final_beat;

    assign tm_w     = {WIDTH{TM0}};
    assign par_w    = in_a ^ in_b ^ tm_w ^ in_c ^ ~in_d;
    assign exp_w    = TM0 ? ~(par_w ^ in_seed) : ~par_w;
    assign syn_w    = in_data ^ exp_w;
    assign beat_err = |syn_w;

    assign in_ready = (state_q != StReport);
    assign accept   = in_valid && in_ready;
    // In ACC, beats_q already holds the count so far; reaching FRAME_LEN-1 means this is the last slot.
    assign final_beat = in_last || ((state_q == StAcc) && (beats_q == BW'(FRAME_LEN - 1)));

    always_comb begin
        state_d = state_q;
        syn_d   = syn_q;
        errb_d  = errb_q;
        beats_d = beats_q;
        first_d = first_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    syn_d   = syn_w;
                    errb_d  = BW'(beat_err);
                    beats_d = BW'(1);
                    first_d = '0;
                    state_d = final_beat ? StReport : StAcc;
                end
            end
            StAcc: begin
                if (accept) begin
                    syn_d   = syn_q | syn_w;
                    errb_d  = errb_q + BW'(beat_err);
                    beats_d = beats_q + BW'(1);
                    if (beat_err && (errb_q == '0)) begin
                        first_d = beats_q[IW-1:0];
                    end
                    state_d = final_beat ? StReport : StAcc;
                end
            end
            StReport: begin
                if (rpt_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear wins over a same-cycle error; the increment is dropped.
    always_comb begin
        tot_d    = tot_q;
        sticky_d = sticky_q;
        if (clr_stats) begin
            tot_d    = '0;
            sticky_d = 1'b0;
        end else if (accept && beat_err) begin
            sticky_d = 1'b1;
            if (!(&tot_q)) begin
                tot_d = tot_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            syn_q    <= '0;
            errb_q   <= '0;
            beats_q  <= '0;
            first_q  <= '0;
            tot_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            syn_q    <= syn_d;
            errb_q   <= errb_d;
            beats_q  <= beats_d;
            first_q  <= first_d;
            tot_q    <= tot_d;
            sticky_q <= sticky_d;
        end
    end

    assign rpt_valid     = (state_q == StReport);
    assign rpt_syndrome  = syn_q;
    assign rpt_err_beats = errb_q;
    assign rpt_beats     = beats_q;
    assign rpt_first_err = first_q;
    assign err_total     = tot_q;
    assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_s35932_crc_checker.sv
// Scoreboard bench for s35932_crc_checker: a lane-level reference model queues expected frame
// reports; a negedge monitor pops and compares them on each report handshake.
module tb_s35932_crc_checker;

    localparam int unsigned W  = 32;
    localparam int unsigned FL = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned BW = $clog2(FL + 1);
    localparam int unsigned IW = $clog2(FL);

    logic          CK = 1'b0;
    logic          RESET_N;
    logic          TM0;
    logic          in_valid, in_ready, in_last;
    logic [W-1:0]  in_data, in_a, in_b, in_c, in_d, in_seed;
    logic          rpt_valid, rpt_ready;
    logic [W-1:0]  rpt_syndrome;
    logic [BW-1:0] rpt_err_beats, rpt_beats;
    logic [IW-1:0] rpt_first_err;
    logic [CW-1:0] err_total;
    logic          err_sticky, clr_stats;

    s35932_crc_checker #(.WIDTH(W), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .CK(CK), .RESET_N(RESET_N), .TM0(TM0), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .in_d(in_d), .in_seed(in_seed), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_syndrome(rpt_syndrome), .rpt_err_beats(rpt_err_beats), .rpt_beats(rpt_beats),
        .rpt_first_err(rpt_first_err), .err_total(err_total), .err_sticky(err_sticky),
        .clr_stats(clr_stats)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [W-1:0] syn;
        int           errb;
        int           beats;
        int           first;
        int           tot;
        bit           sticky;
    } rpt_t;

    rpt_t         exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    // Reference model state for the frame in progress and the running statistics.
    logic [W-1:0] f_syn;
    int           f_beats = 0, f_errb = 0, f_first = 0;
    int           m_tot = 0;
    bit           m_sticky = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] model_exp(input bit tm, input logic [W-1:0] a, b, c, d, s);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            bit p;
            p    = a[i] ^ b[i] ^ tm ^ c[i] ^ ~d[i];
            r[i] = tm ? ~(p ^ s[i]) : ~p;
        end
        return r;
    endfunction

    // Drives one beat starting at posedge+#1, waits for in_ready, and returns after the accept edge.
    task automatic send_beat(input bit tm, input logic [W-1:0] a, b, c, d, s, flip,
                             input bit last, input bit clr, output int waits);
        logic [W-1:0] syn;
        bit           err;
        TM0 = tm; in_a = a; in_b = b; in_c = c; in_d = d; in_seed = s; in_last = last;
        in_data  = model_exp(tm, a, b, c, d, s) ^ flip;
        in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge CK); #1;
            waits++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        clr_stats = clr;
        syn = flip;
        err = (syn != '0);
        if (f_beats == 0) begin
            f_syn = syn; f_errb = int'(err); f_first = 0;
        end else begin
            if (err && f_errb == 0) f_first = f_beats;
            f_syn  = f_syn | syn;
            f_errb = f_errb + int'(err);
        end
        f_beats++;
        if (clr) begin
            m_tot = 0; m_sticky = 0;
        end else if (err) begin
            if (m_tot < (1 << CW) - 1) m_tot++;
            m_sticky = 1;
        end
        if (last || f_beats == FL) begin
            exp_q.push_back('{syn: f_syn, errb: f_errb, beats: f_beats, first: f_first,
                              tot: m_tot, sticky: m_sticky});
            f_beats = 0;
        end
        @(posedge CK); #1;
        in_valid  = 1'b0;
        clr_stats = 1'b0;
    endtask

    always @(negedge CK) begin
        if (RESET_N && rpt_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_report", 64'(rpt_valid), 64'd0);
            end else if (rpt_ready) begin
                rpt_t e;
                e = exp_q.pop_front();
                chk("rpt_syndrome", 64'(rpt_syndrome), 64'(e.syn));
                chk("rpt_err_beats", 64'(rpt_err_beats), 64'(e.errb));
                chk("rpt_beats", 64'(rpt_beats), 64'(e.beats));
                chk("rpt_first_err", 64'(rpt_first_err), 64'(e.first));
                chk("err_total", 64'(err_total), 64'(e.tot));
                chk("err_sticky", 64'(err_sticky), 64'(e.sticky));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_rpt_valid"}, 64'(rpt_valid), 64'd0);
        chk({tag, "_rpt_syndrome"}, 64'(rpt_syndrome), 64'd0);
        chk({tag, "_rpt_err_beats"}, 64'(rpt_err_beats), 64'd0);
        chk({tag, "_rpt_beats"}, 64'(rpt_beats), 64'd0);
        chk({tag, "_rpt_first_err"}, 64'(rpt_first_err), 64'd0);
        chk({tag, "_err_total"}, 64'(err_total), 64'd0);
        chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge CK); #1;
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int           w;
        rpt_t         snap;
        logic [W-1:0] ones;
        ones = '1;
        RESET_N = 1'b0; TM0 = 0; in_valid = 0; in_last = 0; in_data = '0; in_a = '0;
        in_b = '0; in_c = '0; in_d = '0; in_seed = '0; rpt_ready = 1'b1; clr_stats = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge CK);
        RESET_N = 1'b1;
        @(posedge CK); #1;

        // Clean 16-beat frame, ended by length alone.
        for (int i = 0; i < 16; i++) send_beat(0, '0, '0, '0, ones, '0, '0, 0, 0, w);
        drain();

        // Test mode with seed; lane 5 flipped on beat 3.
        for (int i = 0; i < 8; i++)
            send_beat(1, '0, '0, '0, ones, 32'h0000FFFF, (i == 3) ? 32'h20 : '0, i == 7, 0, w);
        drain();

        // Single-beat frame with a two-lane error; report must appear the next cycle.
        send_beat(0, $urandom, $urandom, $urandom, $urandom, $urandom, 32'h00018000, 1, 0, w);
        chk("single_rpt_valid", 64'(rpt_valid), 64'd1);
        chk("single_popcount", 64'($countones(rpt_syndrome)), 64'd2);
        drain();

        // Back-pressure on the report while the next beat is held valid.
        rpt_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_beat(1, $urandom, $urandom, $urandom, $urandom, $urandom,
                      (i == 1) ? 32'h4 : '0, i == 2, 0, w);
        snap = exp_q[0];
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_syndrome", 64'(rpt_syndrome), 64'(snap.syn));
            chk("stall_beats", 64'(rpt_beats), 64'(snap.beats));
        end
        @(posedge CK); #1;
        rpt_ready = 1'b1;
        send_beat(0, $urandom, $urandom, $urandom, $urandom, $urandom, '0, 1, 0, w);
        chk("stall_accept_wait", 64'(w), 64'd1);
        drain();

        // Reset mid-frame after beat 7: frame discarded, stats cleared.
        for (int i = 0; i < 8; i++)
            send_beat(0, $urandom, $urandom, $urandom, $urandom, $urandom, 32'h1, 0, 0, w);
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        f_beats = 0; m_tot = 0; m_sticky = 0;
        @(negedge CK);
        RESET_N = 1'b1;
        @(posedge CK); #1;
        for (int i = 0; i < 3; i++)
            send_beat(0, $urandom, $urandom, $urandom, $urandom, $urandom, '0, i == 2, 0, w);
        drain();

        // Saturate the 4-bit error total with 20 erroneous beats.
        for (int i = 0; i < 20; i++)
            send_beat($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom, $urandom,
                      32'h1 << $urandom_range(0, 31), i == 19, 0, w);
        drain();
        chk("sat_err_total", 64'(err_total), 64'd15);
        chk("sat_err_sticky", 64'(err_sticky), 64'd1);
        send_beat(0, $urandom, $urandom, $urandom, $urandom, $urandom, 32'h80000000, 1, 1, w);
        chk("clr_err_total", 64'(err_total), 64'd0);
        chk("clr_err_sticky", 64'(err_sticky), 64'd0);
        drain();

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(1, FL);
            for (int i = 0; i < len; i++) begin
                logic [W-1:0] flip;
                flip = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
                send_beat($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom,
                          $urandom, flip, (i == len - 1) && (len < FL || $urandom_range(0, 1) == 1),
                          0, w);
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/s35932_crc_checker.md
# s35932_crc_checker

Receive-side checker for the s35932 check-word lanes. The encoder computes each lane's check bit from an XOR tree over the four operand bits, optionally folded with a seed bit in test mode. This block takes the transmitted check word and its operand words over a valid/ready stream and recomputes the expected word per beat. It accumulates per-frame syndromes and error counts, then presents one frame report per frame to the scan/diagnostic logic.

## Interface
- WIDTH, 32, lanes per beat (one check bit per lane)
- FRAME_LEN, 16, maximum beats per frame (≥2)
- CNT_W, 16, width of the running error-beat total
- CK  in  1  clock; all state updates on rising edge
- RESET_N  in  1  reset; one clock, asynchronous, active-low
- TM0  in  1  test-mode select, sampled with each accepted beat
- in_valid  in  1  beat present
- in_ready  out  1  block accepts beat
- in_last  in  1  beat ends frame early
- in_data  in  WIDTH  received check word
- in_a, in_b, in_c, in_d, in_seed  in  WIDTH each  operand words
- rpt_valid  out  1  frame report present
- rpt_ready  in  1  report consumer ready
- rpt_syndrome  out  WIDTH  OR of all beat syndromes in frame
- rpt_err_beats  out  $clog2(FRAME_LEN+1)  beats with nonzero syndrome
- rpt_beats  out  $clog2(FRAME_LEN+1)  beats in frame
- rpt_first_err  out  $clog2(FRAME_LEN)  index of first erroneous beat (0 if none)
- err_total  out  CNT_W  saturating count of erroneous beats since reset/clear
- err_sticky  out  1  set on any erroneous beat
- clr_stats  in  1  synchronous clear of err_total and err_sticky

## Operation
- Per lane i:
  - P = a^b^TM0^c^~d
  - exp = TM0 ? ~(P^seed) : ~P
  - syndrome[i] = data[i]^exp[i]
  - A beat is erroneous if its syndrome is nonzero.
- Accept when in_valid && in_ready.
- FSM states: IDLE, ACC, REPORT.
  - IDLE -> ACC on an accepted beat that is not final.
  - IDLE or ACC -> REPORT on an accepted final beat. A beat is final if in_last=1 or it is beat number FRAME_LEN.
  - REPORT -> IDLE when rpt_valid && rpt_ready.
- The first beat of a frame loads the accumulators. Later beats OR the syndrome and increment the counts.
- rpt_first_err latches the index of the first erroneous beat only.
- in_ready = (state != REPORT).
- rpt_valid = (state == REPORT). rpt_* are held stable until the handshake.
- A single-beat frame (in_last on beat 0) is legal: rpt_beats=1.
- err_total increments by 1 per erroneous accepted beat and saturates at 2^CNT_W-1.
- clr_stats has priority over the same-cycle increment; that increment is lost.
- err_sticky set has priority over nothing else; clr_stats clears it even if an error arrives the same cycle.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, rpt_valid=0
  - all rpt_* = 0
  - err_total = 0, err_sticky = 0
- Syndrome is combinational from beat inputs. All accumulators are registered on accept.
- Report latency: rpt_valid rises the cycle after the final beat is accepted.
- in_ready is low from that cycle until the cycle after the report handshake. The minimum gap between frames is 1 idle cycle.
- in_valid while in_ready=0 is ignored; the source holds the beat.
- Reset asserted mid-frame or mid-report discards the frame immediately. No report is produced.
- TM0 may change between beats of a frame; each beat uses its own sampled value.

## Test plan
- TM0=0; a=b=c=0; d=all-ones; seed=0. P=0, so data=all-ones is clean.
  - Required: 16-beat frame gives rpt_beats=16, rpt_err_beats=0, rpt_syndrome=0, err_total=0.
- TM0=1; a=b=c=0; d=all-ones; seed=0x0000FFFF. Expected word = 0xFFFF0000 ^ 0xFFFFFFFF.
  - Apply data = correct word except lane 5 flipped on beat 3.
  - Required: syndrome=0x20, err_beats=1, first_err=3, err_sticky=1.
- Frame with in_last on beat 0 carrying a 2-lane error.
  - Required: rpt_valid next cycle; beats=1; popcount(syndrome)=2; err_total=1.
- Hold rpt_ready=0 for 5 cycles while in_valid=1.
  - Required: in_ready=0 and the report stays stable throughout.
  - Required: the next frame's beat 0 is accepted the cycle after the handshake.
- CNT_W=4; 20 erroneous beats.
  - Required: err_total saturates at 15.
  - Then clr_stats together with an erroneous beat. Required: err_total=0 and err_sticky=0.
- Assert RESET_N low mid-frame after beat 7.
  - Required: all outputs return to reset values asynchronously and no report appears.
  - Required: the next frame counts beats from 1.
